// File: rtl/arc_mem_pkg.sv
// Shared types and constants for the ARC memory controller.
package arc_mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    typedef enum logic {
        OpRd,
        OpWr
    } op_e;

    // jmpl to the start of the user region
    localparam logic [31:0] BootWord        = 32'h81C0_2800;
    localparam int unsigned UserBaseDefault = 2048;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/arc_mem_bank.sv
// Single-port word array with byte-enabled synchronous write and asynchronous read.
module arc_mem_bank #(
    parameter int unsigned DataW = 32,
    parameter int unsigned Words = 4,
    parameter int unsigned IdxW  = 2
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [IdxW-1:0]    idx_i,
    input  logic [DataW-1:0]   wdata_i,
    input  logic [DataW/8-1:0] be_i,
    output logic [DataW-1:0]   rdata_o
);

    logic [DataW-1:0] mem_q [Words];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < DataW / 8; i++) begin
                if (be_i[i]) mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/arc_mem_ctrl.sv
// ARC main memory controller: req/ack FSM, region decode and error reporting.
// Define ARC_MEM_BOOT_VECTOR_EN to make system word 0 a read-only boot vector.
module arc_mem_ctrl
    import arc_mem_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned SYS_WORDS  = 4,
    parameter int unsigned USER_BASE  = UserBaseDefault,
    parameter int unsigned USER_WORDS = 32,
    parameter int unsigned LATENCY    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    input  logic                rd,
    input  logic                wr,
    output logic [DATA_W-1:0]   rdata,
    output logic                ack,
    output logic                err,
    output logic                busy
);

    localparam int unsigned DW       = DATA_W / 8;
    localparam int unsigned CntW     = clog2(LATENCY) + 1;
    localparam int unsigned SysIdxW  = (SYS_WORDS > 1) ? clog2(SYS_WORDS) : 1;
    localparam int unsigned UserIdxW = (USER_WORDS > 1) ? clog2(USER_WORDS) : 1;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [31:0]         addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DW-1:0]       be_q;
    op_e                 op_q;
    logic                op_err_q;
    logic                latch_en;

    logic                sys_hit, user_hit, align_err, boot_err, acc_err, we;
    logic [SysIdxW-1:0]  sys_idx;
    logic [UserIdxW-1:0] user_idx;
    logic [DATA_W-1:0]   sys_rdata, user_rdata, word;

    // Decode always works on the latched request
    always_comb begin
        sys_hit   = addr_q < SYS_WORDS * DW;
        user_hit  = (addr_q >= USER_BASE) && (addr_q < USER_BASE + USER_WORDS * DW);
        align_err = (addr_q % DW) != 0;
        sys_idx   = SysIdxW'(addr_q / DW);
        user_idx  = UserIdxW'((addr_q - USER_BASE) / DW);
`ifdef ARC_MEM_BOOT_VECTOR_EN
        boot_err  = (op_q == OpWr) && sys_hit && (sys_idx == '0);
        word      = sys_hit ? ((sys_idx == '0) ? DATA_W'(BootWord) : sys_rdata) : user_rdata;
`else
        boot_err  = 1'b0;
        word      = sys_hit ? sys_rdata : user_rdata;
`endif
        acc_err   = op_err_q || align_err || !(sys_hit || user_hit) || boot_err;
        we        = (state_q == StResp) && (op_q == OpWr) && !acc_err;
    end

    arc_mem_bank #(
        .DataW (DATA_W),
        .Words (SYS_WORDS),
        .IdxW  (SysIdxW)
    ) u_sys_bank (
        .clk_i   (clk),
        .we_i    (we && sys_hit),
        .idx_i   (sys_idx),
        .wdata_i (wdata_q),
        .be_i    (be_q),
        .rdata_o (sys_rdata)
    );

    arc_mem_bank #(
        .DataW (DATA_W),
        .Words (USER_WORDS),
        .IdxW  (UserIdxW)
    ) u_user_bank (
        .clk_i   (clk),
        .we_i    (we && user_hit),
        .idx_i   (user_idx),
        .wdata_i (wdata_q),
        .be_i    (be_q),
        .rdata_o (user_rdata)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        latch_en = 1'b0;
        case (state_q)
            StIdle: begin
                if (rd || wr) begin
                    latch_en = 1'b1;
                    cnt_d    = CntW'(LATENCY - 1);
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                    // Load read data on entry to RESP so it is visible with ack
                    if (op_q == OpRd) rdata_d = acc_err ? '0 : word;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (latch_en) begin
            addr_q   <= addr;
            wdata_q  <= wdata;
            be_q     <= be;
            op_q     <= rd ? OpRd : OpWr;
            op_err_q <= rd && wr;
        end
    end

    assign rdata = rdata_q;
    assign ack   = state_q == StResp;
    assign err   = ack && acc_err;
    assign busy  = state_q != StIdle;

endmodule

// File: tb/tb_arc_mem_ctrl.sv
// Randomised and directed bench for arc_mem_ctrl against a word-array reference model.
module tb_arc_mem_ctrl;

    localparam int unsigned LAT   = 2;
    localparam int unsigned UBASE = 2048;
    localparam logic [31:0] BOOT  = 32'h81C0_2800;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] rdata;
    logic        ack, err, busy;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] sys_m [4];
    logic [31:0] user_m [32];
    logic [31:0] rdata_m = '0;

    always #5 clk = ~clk;

    arc_mem_ctrl #(
        .DATA_W     (32),
        .SYS_WORDS  (4),
        .USER_BASE  (UBASE),
        .USER_WORDS (32),
        .LATENCY    (LAT)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .wdata (wdata),
        .be    (be),
        .rd    (rd),
        .wr    (wr),
        .rdata (rdata),
        .ack   (ack),
        .err   (err),
        .busy  (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] a);
`ifdef ARC_MEM_BOOT_VECTOR_EN
        if (a == 0) return BOOT;
`endif
        if (a < 16) return sys_m[a / 4];
        return user_m[(a - UBASE) / 4];
    endfunction

    task automatic model(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, output bit e);
        bit          in_sys, in_user;
        logic [31:0] wd;
        in_sys  = a < 16;
        in_user = (a >= UBASE) && (a < UBASE + 128);
        e = (r && w) || (a % 4 != 0) || !(in_sys || in_user);
`ifdef ARC_MEM_BOOT_VECTOR_EN
        if (w && a == 0) e = 1'b1;
`endif
        if (!e && w) begin
            wd = model_word(a);
            for (int i = 0; i < 4; i++) if (b[i]) wd[8*i +: 8] = d[8*i +: 8];
            if (in_sys) sys_m[a / 4] = wd;
            else user_m[(a - UBASE) / 4] = wd;
        end
        if (r) rdata_m = e ? 32'h0 : model_word(a);
    endtask

    // Called at #1 after a posedge with the DUT idle; returns with the DUT idle again
    task automatic do_access(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] b, input string tag);
        bit   e_exp;
        int   cyc;
        bit   got_ack;
        logic got_err;
        model(r, w, a, d, b, e_exp);
        rd = r; wr = w; addr = a; wdata = d; be = b;
        cyc = 0; got_ack = 1'b0; got_err = 1'bx;
        while (!got_ack && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            rd = 1'b0; wr = 1'b0;
            if (ack) begin
                got_ack = 1'b1;
                got_err = err;
            end
        end
        check({tag, " latency"}, 32'(cyc), 32'(LAT + 1));
        check({tag, " err"}, 32'(got_err), 32'(e_exp));
        check({tag, " rdata"}, rdata, rdata_m);
        @(posedge clk); #1;
    endtask

    initial begin
        int          ack_t [3];
        int          k;
        logic [31:0] old, a;
        bit          r, w;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset ack", 32'(ack), 32'h0);
        check("reset err", 32'(err), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset rdata", rdata, 32'h0);

        for (int i = 0; i < 4; i++) do_access(1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF, "init sys");
        for (int i = 0; i < 32; i++)
            do_access(1'b0, 1'b1, UBASE + 32'(i * 4), $urandom, 4'hF, "init user");

        do_access(1'b0, 1'b1, 2048, 32'hDEAD_BEEF, 4'hF, "wr 2048");
        do_access(1'b1, 1'b0, 2048, 32'h0, 4'h0, "rd 2048");
        check("rd 2048 value", rdata, 32'hDEAD_BEEF);
        do_access(1'b0, 1'b1, 2052, 32'h1122_3344, 4'hF, "wr 2052");
        do_access(1'b0, 1'b1, 2052, 32'hAABB_CCDD, 4'b0101, "wr 2052 be");
        do_access(1'b1, 1'b0, 2052, 32'h0, 4'h0, "rd 2052");
        check("rd 2052 merge", rdata, 32'h11BB_33DD);
        do_access(1'b0, 1'b1, 2052, 32'h5555_5555, 4'h0, "wr be0");

        do_access(1'b1, 1'b0, 32'h803, 32'h0, 4'h0, "misaligned");
        do_access(1'b1, 1'b0, 2048 + 128, 32'h0, 4'h0, "range");
        do_access(1'b1, 1'b1, 2048, 32'h1234_5678, 4'hF, "rd+wr");
        do_access(1'b0, 1'b1, 32'h803, 32'h0BAD_0BAD, 4'hF, "misaligned wr");
        do_access(1'b1, 1'b0, 2048, 32'h0, 4'h0, "rd 2048 kept");
        check("2048 unchanged", rdata, 32'hDEAD_BEEF);

`ifdef ARC_MEM_BOOT_VECTOR_EN
        do_access(1'b1, 1'b0, 0, 32'h0, 4'h0, "boot rd");
        check("boot word", rdata, BOOT);
        do_access(1'b0, 1'b1, 0, 32'hFFFF_FFFF, 4'hF, "boot wr");
        do_access(1'b1, 1'b0, 0, 32'h0, 4'h0, "boot rerd");
        check("boot word kept", rdata, BOOT);
`else
        do_access(1'b0, 1'b1, 0, 32'hCAFE_F00D, 4'hF, "word0 wr");
        do_access(1'b1, 1'b0, 0, 32'h0, 4'h0, "word0 rd");
        check("word0 value", rdata, 32'hCAFE_F00D);
`endif

        // Reset in the middle of a write aborts it
        old = user_m[2];
        wr = 1'b1; addr = 2056; wdata = ~old; be = 4'hF;
        @(posedge clk); #1;
        wr = 1'b0;
        check("abort busy wait", 32'(busy), 32'h1);
        @(posedge clk); #1;
        check("abort no ack", 32'(ack), 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rdata_m = '0;
        check("abort busy drop", 32'(busy), 32'h0);
        check("abort ack", 32'(ack), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort idle ack", 32'(ack), 32'h0);
        end
        do_access(1'b1, 1'b0, 2056, 32'h0, 4'h0, "rd 2056");
        check("abort old value", rdata, old);

        // Back-to-back reads with rd held high
        ack_t = '{-1, -1, -1};
        k = 0;
        rd = 1'b1; addr = 2048;
        for (int t = 1; t <= 12; t++) begin
            @(posedge clk); #1;
            if (ack && k < 3) begin
                ack_t[k] = t;
                check("b2b rdata", rdata, user_m[k]);
                k++;
                if (k < 3) addr = UBASE + 32'(k * 4);
                else rd = 1'b0;
            end
            check("b2b busy", 32'(busy), 32'((t % (LAT + 2)) != 0));
        end
        rdata_m = user_m[2];
        for (int i = 0; i < 3; i++)
            check("b2b ack cycle", 32'(ack_t[i]), 32'((LAT + 2) * i + LAT + 1));
        @(posedge clk); #1;

        // Randomised accesses over both regions, misaligned and out-of-range addresses
        for (int n = 0; n < 120; n++) begin
            case ($urandom_range(0, 5))
                0:       a = 32'($urandom_range(0, 3) * 4);
                1, 2:    a = UBASE + 32'($urandom_range(0, 31) * 4);
                3:       a = UBASE + 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
                4: begin
                    case ($urandom_range(0, 3))
                        0:       a = 16;
                        1:       a = UBASE - 4;
                        2:       a = UBASE + 128;
                        default: a = $urandom;
                    endcase
                end
                default: a = 32'($urandom_range(0, 3) * 4 + $urandom_range(0, 1) * UBASE);
            endcase
            r = $urandom_range(0, 1) == 1;
            w = !r || ($urandom_range(0, 7) == 0);
            do_access(r, w, a, $urandom, 4'($urandom), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
